// File: rtl/fft_pkg.sv
// Shared FFT datapath constants, phase encoding and complex sample type.
package fft_pkg;

    localparam int unsigned DATA_W    = 24;
    localparam int unsigned TW_FRAC   = 8;
    localparam int unsigned SDF_DELAY = 8;
    localparam int unsigned PROD_W    = 2 * DATA_W;

    // Stage phase encoding driven by the twiddle ROM; code 3 behaves as FILL.
    localparam logic [1:0] FILL = 2'd0;
    localparam logic [1:0] BFLY = 2'd1;
    localparam logic [1:0] TWID = 2'd2;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    function automatic logic signed [PROD_W-1:0] sext_prod(input logic signed [DATA_W-1:0] x);
        return PROD_W'(x);
    endfunction

endpackage

// File: rtl/cmul_q8.sv
// Combinational complex multiply by a Q8 twiddle, 48-bit accumulate, shift by TW_FRAC.
// Rounding (half up) before the shift is enabled by defining SDF_ROUND_EN.
module cmul_q8
    import fft_pkg::*;
(
    input  cplx_t a,
    input  cplx_t w,
    output cplx_t p_c
);

`ifdef SDF_ROUND_EN
    localparam logic signed [PROD_W-1:0] RND = PROD_W'(1) <<< (TW_FRAC - 1);
`else
    localparam logic signed [PROD_W-1:0] RND = '0;
`endif

    logic signed [PROD_W-1:0] re_acc;
    logic signed [PROD_W-1:0] im_acc;

    always_comb begin
        re_acc = sext_prod(a.re) * sext_prod(w.re) - sext_prod(a.im) * sext_prod(w.im) + RND;
        im_acc = sext_prod(a.re) * sext_prod(w.im) + sext_prod(a.im) * sext_prod(w.re) + RND;
        p_c.re = DATA_W'(re_acc >>> TW_FRAC);
        p_c.im = DATA_W'(im_acc >>> TW_FRAC);
    end

endmodule

// File: rtl/sdf_stage_8.sv
// Radix-2 single-path delay-feedback FFT stage with an 8-entry complex delay line.
// Define SDF_ROUND_EN to round (rather than floor) the twiddle product.
module sdf_stage_8
    import fft_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] din_r,
    input  logic signed [DATA_W-1:0] din_i,
    input  logic        [1:0]        state,
    input  logic signed [DATA_W-1:0] w_r,
    input  logic signed [DATA_W-1:0] w_i,
    output logic signed [DATA_W-1:0] dout_r,
    output logic signed [DATA_W-1:0] dout_i,
    output logic                     out_valid
);

    cplx_t [SDF_DELAY-1:0] dl_q, dl_d;
    cplx_t                 dout_q, dout_d;
    logic                  out_valid_q, out_valid_d;

    cplx_t din, tw, oldest, push, prod_c;

    assign din    = '{re: din_r, im: din_i};
    assign tw     = '{re: w_r, im: w_i};
    assign oldest = dl_q[SDF_DELAY-1];

    cmul_q8 u_cmul (
        .a   (oldest),
        .w   (tw),
        .p_c (prod_c)
    );

    // Phase decode, output update and delay-line shift for one accepted sample.
    always_comb begin
        push        = din;
        dl_d        = dl_q;
        dout_d      = dout_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            case (state)
                BFLY: begin
                    dout_d.re   = DATA_W'(oldest.re + din.re);
                    dout_d.im   = DATA_W'(oldest.im + din.im);
                    push.re     = DATA_W'(oldest.re - din.re);
                    push.im     = DATA_W'(oldest.im - din.im);
                    out_valid_d = 1'b1;
                end
                TWID: begin
                    dout_d      = prod_c;
                    out_valid_d = 1'b1;
                end
                default: begin
                    push = din;
                end
            endcase
            dl_d = {dl_q[SDF_DELAY-2:0], push};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_q        <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            dl_q        <= dl_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign dout_r    = dout_q.re;
    assign dout_i    = dout_q.im;
    assign out_valid = out_valid_q;

endmodule

// File: doc/sdf_stage_8.md
SDF_STAGE_8 -- requirements
Module: sdf_stage_8

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-003 in_valid  input  1  sample-accept strobe; the delay line and output register advance only when in_valid=1.
REQ-004 din_r, din_i  input  24 each  signed two's-complement input sample.
REQ-005 state  input  2  stage phase from the twiddle ROM: 0=fill, 1=butterfly, 2=twiddle; 3 is handled as 0.
REQ-006 w_r, w_i  input  24 each  signed twiddle, 8 fractional bits (256 = +1.0), valid in phase 2.
REQ-007 dout_r, dout_i  output  24 each  registered signed output sample.
REQ-008 out_valid  output  1  registered; high for exactly the cycles dout carries a produced sample.

Function
REQ-009 Delay line: 8 complex entries, 24+24 bits each, FIFO order; one shift per accepted sample; no shift when in_valid=0.
REQ-010 Phase 0 on accepted sample: din enters the delay line; out_valid=0 next cycle.
REQ-011 Phase 1 on accepted sample: with d = oldest entry, dout <= d+din, and d-din enters the delay line.
REQ-012 Phase 2 on accepted sample: dout <= d*w (complex multiply), and din enters the delay line.
REQ-013 Latency: dout/out_valid update on the clock edge that accepts the sample (1-cycle registered latency).
REQ-014 in_valid=0: dout holds its value, out_valid=0, delay line holds.
REQ-015 Add/subtract: 24-bit, wrap modulo 2^24, no saturation.
REQ-016 Multiply: re = d_r*w_r - d_i*w_i and im = d_r*w_i + d_i*w_r at 48-bit full precision, then arithmetic shift right by 8, keeping the low 24 bits (wrap).
REQ-017 Phase sequence 1 (8 samples) then 2 (8 samples) then 1 repeats; the stage trusts the state input and performs no independent sequencing.

Reset
REQ-018 While rst_n=0: delay line = 0, dout_r = dout_i = 0, out_valid = 0.
REQ-019 Assertion mid-frame discards all in-flight data; after release, operation restarts with no residue from the previous frame.

Configuration
REQ-020 Macro SDF_ROUND_EN defined: 128 is added to each 48-bit product sum before the shift (round half up).
REQ-021 Macro SDF_ROUND_EN absent: plain arithmetic shift (floor truncation).
REQ-022 Phases 0 and 1 are identical with and without the macro.

Structure
REQ-023 Shared package fft_pkg holds DATA_W=24, TW_FRAC=8, SDF_DELAY=8, and the phase encoding constants (FILL=0, BFLY=1, TWID=2).
REQ-024 The complex multiply, including the rounding option, lives in sub-module cmul_q8 (combinational); the stage instantiates it once.

Verification
REQ-025 Impulse test: din = 256+0j then 15 zeros, state 0x8, 1x8, 2x8 -> out 1 = 256+0j, outs 2-8 = 0, out 9 = 256+0j (W=256+0j), outs 10-16 = 0.
REQ-026 Constant test: 16 samples of 100+0j -> outs 1-8 = 200+0j, outs 9-16 = 0+0j.
REQ-027 Twiddle test: x[9] = 256, all others 0, w at out 10 = 237-98j -> out 10 = -237+98j.
REQ-028 Rounding test: x[1] = 1, others 0 -> out 10 = 0-1j without SDF_ROUND_EN, and 1+0j with it.
REQ-029 Stall test: in_valid=0 for 3 cycles mid-phase-1 -> out_valid=0 during the gap, dout holds, and the resumed outputs match the no-stall run.
REQ-030 Reset test: rst_n pulsed at sample 5 of phase 1 -> outputs = 0 immediately, and the next frame matches REQ-026.
